// File: rtl/pwm_softstart_controller.sv
`default_nettype none
// ============================================================================
// Module   : pwm_softstart_controller
// Desc     : Period tick counter plus slew-limited soft-start/soft-stop and fault
//            sequencing of the highside/lowside tick counts of one PWM half-bridge.
//            Build option PWM_SOFTSTART_FAULT_LATCH_EN: FAULT is held until clear_fault.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_softstart_controller #(
    parameter int TICK_COUNT_PERIOD = 100,
    parameter int DEADTIME_HS_TO_LS = 12,
    parameter int DEADTIME_LS_TO_HS = 12,
    parameter int BITWIDTH          = $clog2(TICK_COUNT_PERIOD) + 1,
    parameter int RAMP_STEP         = 1,
    parameter int RAMP_PRESCALER    = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [BITWIDTH-1:0] target_highside,
    input  logic                fault,
    input  logic                clear_fault,
    output logic [BITWIDTH-1:0] tick_counter,
    output logic [BITWIDTH-1:0] tick_count_highside,
    output logic [BITWIDTH-1:0] tick_count_lowside,
    output logic                load_enable,
    output logic                gates_enable,
    output logic                running,
    output logic                fault_active
);

    localparam int                c_PW          = (RAMP_PRESCALER > 1) ? $clog2(RAMP_PRESCALER) : 1;
    localparam logic [BITWIDTH:0] c_MAX_ON      = (BITWIDTH+1)'(TICK_COUNT_PERIOD - 1 - DEADTIME_HS_TO_LS - DEADTIME_LS_TO_HS);
    localparam logic [BITWIDTH-1:0] c_MAX_ON_N  = BITWIDTH'(TICK_COUNT_PERIOD - 1 - DEADTIME_HS_TO_LS - DEADTIME_LS_TO_HS);
    localparam logic [BITWIDTH:0] c_STEP        = (BITWIDTH+1)'(RAMP_STEP);
    localparam logic [BITWIDTH-1:0] c_TICK_LAST = BITWIDTH'(TICK_COUNT_PERIOD - 1);
    localparam logic [BITWIDTH-1:0] c_TICK_SLOT = BITWIDTH'(TICK_COUNT_PERIOD - 2);
    localparam logic [c_PW-1:0]   c_PRESC_LAST  = c_PW'(RAMP_PRESCALER - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RAMP  = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_FAULT = 3'd4;

    logic [2:0]          r_state;
    logic [BITWIDTH-1:0] r_tick;
    logic [BITWIDTH-1:0] r_hs_cur;
    logic [BITWIDTH-1:0] r_ls;
    logic                r_load;
    logic [c_PW-1:0]     r_presc;

    logic [2:0]          w_state_next;
    logic [BITWIDTH-1:0] w_hs_next;
    logic [BITWIDTH-1:0] w_ls_next;
    logic                w_load_next;
    logic [c_PW-1:0]     w_presc_next;
    logic [BITWIDTH:0]   w_clamped;
    logic [BITWIDTH:0]   w_goal;
    logic [BITWIDTH:0]   w_hs_ext;
    logic [BITWIDTH:0]   w_stepped;
    logic                w_slot;
    logic                w_active;
    logic                w_update;
    logic                w_fault_exit;

`ifdef PWM_SOFTSTART_FAULT_LATCH_EN
    assign w_fault_exit = clear_fault;
`else
    logic w_unused_clear_fault;
    assign w_unused_clear_fault = clear_fault;
    assign w_fault_exit         = 1'b1;
`endif

    assign w_slot   = (r_tick == c_TICK_SLOT);
    assign w_active = (r_state != c_ST_IDLE) || enable;
    assign w_update = w_slot && (r_presc == c_PRESC_LAST);

    // Slew-limited move of hs_cur toward the goal; lands exactly on the goal, never past it
    always_comb begin
        w_clamped = ({1'b0, target_highside} > c_MAX_ON) ? c_MAX_ON : {1'b0, target_highside};
        w_goal    = enable ? w_clamped : '0;
        w_hs_ext  = {1'b0, r_hs_cur};
        w_stepped = w_goal;
        if (w_goal > w_hs_ext) begin
            if ((w_goal - w_hs_ext) > c_STEP) w_stepped = w_hs_ext + c_STEP;
        end else if ((w_hs_ext - w_goal) > c_STEP) begin
            w_stepped = w_hs_ext - c_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_tick   <= '0;
            r_hs_cur <= '0;
            r_ls     <= '0;
            r_load   <= 1'b0;
            r_presc  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_tick   <= (r_tick == c_TICK_LAST) ? '0 : r_tick + 1'b1;
            r_hs_cur <= w_hs_next;
            r_ls     <= w_ls_next;
            r_load   <= w_load_next;
            r_presc  <= w_presc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hs_next    = r_hs_cur;
        w_ls_next    = r_ls;
        w_load_next  = 1'b0;
        w_presc_next = r_presc;
        if (fault) begin
            w_state_next = c_ST_FAULT;
            w_hs_next    = '0;
            w_ls_next    = '0;
            w_presc_next = '0;
        end else if (r_state == c_ST_FAULT) begin
            if (w_fault_exit) w_state_next = c_ST_IDLE;
        end else if (!w_active) begin
            w_presc_next = '0;
        end else begin
            // Enable edges act on any cycle; only the slot moves the duty values
            if (enable) w_state_next = (r_state == c_ST_RUN) ? c_ST_RUN : c_ST_RAMP;
            else        w_state_next = c_ST_STOP;
            if (w_slot) begin
                w_presc_next = w_update ? '0 : r_presc + 1'b1;
                if (w_update) begin
                    w_hs_next = w_stepped[BITWIDTH-1:0];
                    if (enable) w_state_next = (w_stepped == w_goal) ? c_ST_RUN : c_ST_RAMP;
                    else        w_state_next = (w_stepped == '0) ? c_ST_IDLE : c_ST_STOP;
                end
                if (w_state_next == c_ST_IDLE) begin
                    w_ls_next    = '0;
                    w_presc_next = '0;
                end else begin
                    w_ls_next   = c_MAX_ON_N - w_hs_next;
                    w_load_next = 1'b1;
                end
            end
        end
    end

    assign tick_counter        = r_tick;
    assign tick_count_highside = r_hs_cur;
    assign tick_count_lowside  = r_ls;
    assign load_enable         = r_load;
    assign gates_enable        = (r_state == c_ST_RAMP) || (r_state == c_ST_RUN) || (r_state == c_ST_STOP);
    assign running             = (r_state == c_ST_RUN);
    assign fault_active        = (r_state == c_ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_pwm_softstart_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_softstart_controller
// Desc     : Randomised scoreboard bench; a default instance and a step=4/prescaler=3
//            instance share stimulus and are compared against a period-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_softstart_controller;
    localparam int PERIOD = 100;
    localparam int MAX_ON = 75;
    localparam int W      = 8;
`ifdef PWM_SOFTSTART_FAULT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    typedef struct {
        int tick;
        int hs;
        int ls;
        int gates;
        int run;
        int flt;
    } stat_t;

    logic                 clock = 1'b1;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic                 fault = 1'b0;
    logic                 clear_fault = 1'b0;
    logic [W-1:0]         target_highside = '0;
    logic [1:0][W-1:0]    tick_o, hs_o, ls_o;
    logic [1:0]           load_o, gates_o, run_o, flt_o;

    always #5 clock = ~clock;

    pwm_softstart_controller u_dut0 (
        .clock(clock), .reset(reset), .enable(enable), .target_highside(target_highside),
        .fault(fault), .clear_fault(clear_fault), .tick_counter(tick_o[0]),
        .tick_count_highside(hs_o[0]), .tick_count_lowside(ls_o[0]), .load_enable(load_o[0]),
        .gates_enable(gates_o[0]), .running(run_o[0]), .fault_active(flt_o[0])
    );

    pwm_softstart_controller #(.RAMP_STEP(4), .RAMP_PRESCALER(3)) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .target_highside(target_highside),
        .fault(fault), .clear_fault(clear_fault), .tick_counter(tick_o[1]),
        .tick_count_highside(hs_o[1]), .tick_count_lowside(ls_o[1]), .load_enable(load_o[1]),
        .gates_enable(gates_o[1]), .running(run_o[1]), .fault_active(flt_o[1])
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    gcyc    = 0;
    int    mcyc    = 0;
    int    m_tick  = 0;
    int    m_hs[2], m_ls[2], m_pc[2], m_sess[2], m_set[2], m_flt[2];
    stat_t sq0[$], sq1[$];
    int    lq0[$], lq1[$];
    bit    en_s  = 1'b0;
    int    tgt_s = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, mcyc);
        end
    endfunction

    // Reference: duty moves only at the period slot, by at most the step, on every
    // prescaler-th slot of a session; sessions end when a soft-stop reaches zero.
    task automatic model_edge(input bit r, input bit e, input int t, input bit f, input bit c);
        bit    slot;
        bit    upd;
        int    step, presc, goal, diff;
        stat_t s;
        gcyc++;
        slot   = (m_tick == PERIOD - 2);
        m_tick = r ? 0 : (m_tick + 1) % PERIOD;
        for (int d = 0; d < 2; d++) begin
            step  = (d == 0) ? 1 : 4;
            presc = (d == 0) ? 1 : 3;
            if (r) begin
                m_hs[d] = 0; m_ls[d] = 0; m_pc[d] = 0; m_sess[d] = 0; m_set[d] = 0; m_flt[d] = 0;
            end else if (f) begin
                m_hs[d] = 0; m_ls[d] = 0; m_pc[d] = 0; m_sess[d] = 0; m_set[d] = 0; m_flt[d] = 1;
            end else if (m_flt[d] != 0) begin
                if (!LATCH || c) m_flt[d] = 0;
            end else if (m_sess[d] != 0 || e) begin
                m_sess[d] = 1;
                if (!e) m_set[d] = 0;
                if (slot) begin
                    upd     = (m_pc[d] == presc - 1);
                    m_pc[d] = (m_pc[d] + 1) % presc;
                    if (upd) begin
                        goal = e ? ((t > MAX_ON) ? MAX_ON : t) : 0;
                        diff = goal - m_hs[d];
                        if (diff > step)       m_hs[d] = m_hs[d] + step;
                        else if (diff < -step) m_hs[d] = m_hs[d] - step;
                        else                   m_hs[d] = goal;
                        m_set[d] = (e && m_hs[d] == goal) ? 1 : 0;
                        if (!e && m_hs[d] == 0) begin
                            m_sess[d] = 0;
                            m_pc[d]   = 0;
                        end
                    end
                    if (m_sess[d] != 0) begin
                        m_ls[d] = MAX_ON - m_hs[d];
                        if (d == 0) lq0.push_back(gcyc); else lq1.push_back(gcyc);
                    end else begin
                        m_ls[d] = 0;
                    end
                end
            end
            s.tick  = m_tick;
            s.hs    = m_hs[d];
            s.ls    = m_ls[d];
            s.gates = m_sess[d];
            s.run   = m_set[d];
            s.flt   = m_flt[d];
            if (d == 0) sq0.push_back(s); else sq1.push_back(s);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input int t, input bit f, input bit c);
        @(negedge clock);
        reset           = r;
        enable          = e;
        target_highside = W'(t);
        fault           = f;
        clear_fault     = c;
        model_edge(r, e, t, f, c);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, en_s, tgt_s, 1'b0, 1'b0);
    endtask

    // Monitor: pops the expectation for each cycle and each load strobe
    initial begin
        stat_t s;
        int    exp_load;
        forever begin
            @(posedge clock);
            #1;
            mcyc++;
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 ? sq0.size() : sq1.size()) == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL d%0d_scoreboard: no expectation for cycle %0d", d, mcyc);
                end else begin
                    s = (d == 0) ? sq0.pop_front() : sq1.pop_front();
                    check($sformatf("d%0d_tick", d), int'(tick_o[d]), s.tick);
                    check($sformatf("d%0d_highside", d), int'(hs_o[d]), s.hs);
                    check($sformatf("d%0d_lowside", d), int'(ls_o[d]), s.ls);
                    check($sformatf("d%0d_gates_enable", d), int'(gates_o[d]), s.gates);
                    check($sformatf("d%0d_running", d), int'(run_o[d]), s.run);
                    check($sformatf("d%0d_fault_active", d), int'(flt_o[d]), s.flt);
                end
                exp_load = 0;
                if (d == 0 && lq0.size() > 0 && lq0[0] == mcyc) begin
                    exp_load = 1;
                    void'(lq0.pop_front());
                end
                if (d == 1 && lq1.size() > 0 && lq1[0] == mcyc) begin
                    exp_load = 1;
                    void'(lq1.pop_front());
                end
                check($sformatf("d%0d_load_enable", d), int'(load_o[d]), exp_load);
            end
        end
    end

    initial begin
        int n, r;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Soft-start to 40, then clamp at 75, then back to 40
        en_s = 1'b1; tgt_s = 40; run_cycles(45 * PERIOD);
        tgt_s = 90; run_cycles(40 * PERIOD);
        tgt_s = 40; run_cycles(40 * PERIOD);

        // Soft-stop, resume from hs=20, then full stop to IDLE
        en_s = 1'b0;
        for (int i = 0; i < 3000 && m_hs[0] != 20; i++) cyc(1'b0, en_s, tgt_s, 1'b0, 1'b0);
        en_s = 1'b1; run_cycles(25 * PERIOD);
        en_s = 1'b0; run_cycles(50 * PERIOD);

        // Fault mid-ramp at tick 37; clear while fault held must be ignored
        en_s = 1'b1; tgt_s = 60; run_cycles(20 * PERIOD);
        for (int i = 0; i < 2 * PERIOD && m_tick != 37; i++) cyc(1'b0, en_s, tgt_s, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, en_s, tgt_s, 1'b1, 1'b0);
        cyc(1'b0, en_s, tgt_s, 1'b1, 1'b1);
        run_cycles(3 * PERIOD);
        cyc(1'b0, en_s, tgt_s, 1'b0, 1'b1);
        run_cycles(10 * PERIOD);

        // Small target from idle exercises the coarse step/prescaler instance
        en_s = 1'b0; run_cycles(80 * PERIOD);
        en_s = 1'b1; tgt_s = 10; run_cycles(12 * PERIOD);
        tgt_s = 0; run_cycles(15 * PERIOD);

        // Reset mid-ramp
        en_s = 1'b0; run_cycles(20 * PERIOD);
        en_s = 1'b1; tgt_s = 50; run_cycles($urandom_range(1000, 2500));
        cyc(1'b1, en_s, tgt_s, 1'b0, 1'b0);
        run_cycles(5 * PERIOD);

        // Random segments with sporadic faults, clears and resets
        for (int seg = 0; seg < 25; seg++) begin
            en_s  = ($urandom_range(0, 9) < 7);
            tgt_s = $urandom_range(0, 120);
            n     = $urandom_range(50, 900);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 2999);
                cyc(r == 0, en_s, tgt_s, (r >= 1 && r <= 8), (r >= 9 && r <= 20));
            end
        end

        @(posedge clock);
        #2;
        check("d0_loads_outstanding", lq0.size(), 0);
        check("d1_loads_outstanding", lq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
